// File: rtl/paddle_input_ctrl_pkg.sv
// Shared definitions for the paddle input stage and the display stage.
//
// Contents:
//   CTRL_*          4-bit motion codes carried on the control bus
//   state_t         motion FSM states
//   debug_t         observation bundle exported by paddle_input_ctrl
//   ctrl_of_state   maps an FSM state onto its motion code
package paddle_input_ctrl_pkg;

    localparam logic [3:0] CTRL_IDLE   = 4'b0000;
    localparam logic [3:0] CTRL_RIGHT1 = 4'b0001;
    localparam logic [3:0] CTRL_RIGHT2 = 4'b0011;
    localparam logic [3:0] CTRL_LEFT1  = 4'b0100;
    localparam logic [3:0] CTRL_LEFT2  = 4'b0110;
    localparam logic [3:0] CTRL_PAUSED = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEFT1  = 3'd1,
        ST_LEFT2  = 3'd2,
        ST_RIGHT1 = 3'd3,
        ST_RIGHT2 = 3'd4
    } state_t;

    // level / rise are ordered {pause, left, right}
    typedef struct packed {
        state_t     state;
        logic [2:0] level;
        logic [2:0] rise;
    } debug_t;

    function automatic logic [3:0] ctrl_of_state(input state_t s);
        case (s)
            ST_LEFT1:  return CTRL_LEFT1;
            ST_LEFT2:  return CTRL_LEFT2;
            ST_RIGHT1: return CTRL_RIGHT1;
            ST_RIGHT2: return CTRL_RIGHT2;
            default:   return CTRL_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer followed by a debounce counter for one push-button.
//
// Ports:
//   clock   system clock
//   reset   synchronous, active-low
//   raw     raw button level, asynchronous to clock
//   level   debounced level
//   rise    one-clock pulse, high in the same cycle level goes 0 -> 1
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 200
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 != level) begin
                // Accept the new level once it has disagreed for
                // DEBOUNCE_CYCLES consecutive samples.
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    rise  <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/paddle_input_ctrl.sv
// Paddle input stage: conditions the left/right/pause buttons, tracks
// pause, classifies motion into the display control code and produces
// per-step move strobes for the game core.
//
// Ports:
//   clock       10 kHz system clock
//   reset       synchronous, active-low
//   btn_left    raw left button, active-high
//   btn_right   raw right button, active-high
//   btn_pause   raw pause button, active-high
//   control     motion code (see CTRL_* in the package), registered
//   step_left   one-clock strobe: move one column left, registered
//   step_right  one-clock strobe: move one column right, registered
//   paused      high while paused, registered
//   debug       FSM state plus debounced levels and rise pulses
module paddle_input_ctrl
    import paddle_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200,
    parameter int SPEED2_HOLD     = 5000,
    parameter int STEP1_PERIOD    = 1000,
    parameter int STEP2_PERIOD    = 400
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_pause,
    output logic [3:0] control,
    output logic       step_left,
    output logic       step_right,
    output logic       paused,
    output debug_t     debug
);

    localparam int STEP_MAX = (STEP1_PERIOD > STEP2_PERIOD) ? STEP1_PERIOD : STEP2_PERIOD;
    localparam int HW = (SPEED2_HOLD > 1) ? $clog2(SPEED2_HOLD) : 1;
    localparam int SW = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;

    localparam logic [HW-1:0] HOLD_LAST  = HW'(SPEED2_HOLD - 1);
    localparam logic [SW-1:0] STEP1_LAST = SW'(STEP1_PERIOD - 1);
    localparam logic [SW-1:0] STEP2_LAST = SW'(STEP2_PERIOD - 1);

    logic left_lvl,  left_rise;
    logic right_lvl, right_rise;
    logic pause_lvl, pause_rise;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .clock (clock),
        .reset (reset),
        .raw   (btn_left),
        .level (left_lvl),
        .rise  (left_rise)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .clock (clock),
        .reset (reset),
        .raw   (btn_right),
        .level (right_lvl),
        .rise  (right_rise)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_pause (
        .clock (clock),
        .reset (reset),
        .raw   (btn_pause),
        .level (pause_lvl),
        .rise  (pause_rise)
    );

    state_t        state, state_n;
    logic [HW-1:0] hold,  hold_n;
    logic [SW-1:0] step,  step_n;
    logic [3:0]    control_n;
    logic          left_n, right_n, paused_n;

    logic req_left, req_right, in_left, in_right;

    // Both buttons together cancel out to "no request".
    assign req_left  = left_lvl & ~right_lvl;
    assign req_right = right_lvl & ~left_lvl;
    assign in_left   = (state == ST_LEFT1)  || (state == ST_LEFT2);
    assign in_right  = (state == ST_RIGHT1) || (state == ST_RIGHT2);

    always_comb begin
        state_n  = state;
        hold_n   = hold;
        step_n   = step;
        left_n   = 1'b0;
        right_n  = 1'b0;
        paused_n = paused ^ pause_rise;

        if (pause_rise || paused) begin
            // A pause toggle wins over any direction change in the same
            // cycle; unpausing lands in IDLE so a held direction re-enters
            // fresh on the following clock.
            state_n = ST_IDLE;
            hold_n  = '0;
            step_n  = '0;
        end else if (req_left && !in_left) begin
            state_n = ST_LEFT1;
            hold_n  = '0;
            step_n  = '0;
            left_n  = 1'b1;
        end else if (req_right && !in_right) begin
            state_n = ST_RIGHT1;
            hold_n  = '0;
            step_n  = '0;
            right_n = 1'b1;
        end else if (!req_left && !req_right) begin
            state_n = ST_IDLE;
            hold_n  = '0;
            step_n  = '0;
        end else if (state == ST_LEFT1 || state == ST_RIGHT1) begin
            if (hold == HOLD_LAST) begin
                // Escalation restarts the step period; no strobe here.
                state_n = (state == ST_LEFT1) ? ST_LEFT2 : ST_RIGHT2;
                step_n  = '0;
            end else begin
                hold_n = hold + HW'(1);
                if (step == STEP1_LAST) begin
                    step_n  = '0;
                    left_n  = in_left;
                    right_n = in_right;
                end else begin
                    step_n = step + SW'(1);
                end
            end
        end else begin
            // Speed 2: hold counter stays saturated at its terminal value.
            if (step == STEP2_LAST) begin
                step_n  = '0;
                left_n  = in_left;
                right_n = in_right;
            end else begin
                step_n = step + SW'(1);
            end
        end

        control_n = paused_n ? CTRL_PAUSED : ctrl_of_state(state_n);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            hold       <= '0;
            step       <= '0;
            control    <= CTRL_IDLE;
            step_left  <= 1'b0;
            step_right <= 1'b0;
            paused     <= 1'b0;
        end else begin
            state      <= state_n;
            hold       <= hold_n;
            step       <= step_n;
            control    <= control_n;
            step_left  <= left_n;
            step_right <= right_n;
            paused     <= paused_n;
        end
    end

    always_comb begin
        debug.state = state;
        debug.level = {pause_lvl, left_lvl, right_lvl};
        debug.rise  = {pause_rise, left_rise, right_rise};
    end

endmodule

// File: tb/tb_paddle_input_ctrl.sv
module tb_paddle_input_ctrl;
    import paddle_input_ctrl_pkg::*;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int S1   = 8;
    localparam int S2   = 4;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic btn_left = 1'b0, btn_right = 1'b0, btn_pause = 1'b0;
    logic [3:0] control;
    logic step_left, step_right, paused;
    debug_t debug_dut;

    always #5 clock = ~clock;

    paddle_input_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .SPEED2_HOLD     (HOLD),
        .STEP1_PERIOD    (S1),
        .STEP2_PERIOD    (S2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_pause  (btn_pause),
        .control    (control),
        .step_left  (step_left),
        .step_right (step_right),
        .paused     (paused),
        .debug      (debug_dut)
    );

    int checks = 0;
    int errors = 0;
    int cycle_no = 0;

    // ---------------- reference model ----------------
    // Debounce: a button's accepted level flips once the last DEB
    // synchronized samples (raw samples 2..DEB+1 edges old) all disagree
    // with it. Motion: tracked as direction + age since entry; strobes and
    // speed follow from the age arithmetically.
    bit  hist [3][DEB+2];
    bit  lvl  [3];
    bit  prise;
    bit  m_paused;
    int  m_dir;     // 0 none, 1 left, 2 right
    int  m_age;
    logic [3:0] exp_control;
    logic exp_sl, exp_sr, exp_paused;

    task automatic model_edge(input logic rst_v, input logic l, input logic r, input logic p);
        bit raw [3];
        bit all_diff;
        int req;
        raw[0] = l; raw[1] = r; raw[2] = p;
        if (!rst_v) begin
            for (int b = 0; b < 3; b++) begin
                for (int i = 0; i < DEB + 2; i++) hist[b][i] = 1'b0;
                lvl[b] = 1'b0;
            end
            prise = 0; m_paused = 0; m_dir = 0; m_age = 0;
            exp_control = 4'b0000; exp_sl = 0; exp_sr = 0; exp_paused = 0;
            return;
        end
        // outputs from the accepted levels before this edge
        exp_sl = 0; exp_sr = 0;
        if (prise) begin
            m_paused = !m_paused;
            m_dir = 0;
        end else if (m_paused) begin
            m_dir = 0;
        end else begin
            req = (lvl[0] && !lvl[1]) ? 1 : (lvl[1] && !lvl[0]) ? 2 : 0;
            if (req == 0) begin
                m_dir = 0;
            end else if (req != m_dir) begin
                m_dir = req; m_age = 0;
                if (req == 1) exp_sl = 1; else exp_sr = 1;
            end else begin
                bit strobe;
                m_age++;
                if (m_age < HOLD)       strobe = (m_age % S1) == 0;
                else if (m_age == HOLD) strobe = 0;
                else                    strobe = ((m_age - HOLD) % S2) == 0;
                if (m_dir == 1) exp_sl = strobe; else exp_sr = strobe;
            end
        end
        exp_paused = m_paused;
        if (m_paused)        exp_control = 4'b1111;
        else if (m_dir == 1) exp_control = (m_age >= HOLD) ? 4'b0110 : 4'b0100;
        else if (m_dir == 2) exp_control = (m_age >= HOLD) ? 4'b0011 : 4'b0001;
        else                 exp_control = 4'b0000;
        // debounce update
        prise = 0;
        for (int b = 0; b < 3; b++) begin
            for (int i = DEB + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
            hist[b][0] = raw[b];
            all_diff = 1;
            for (int i = 2; i <= DEB + 1; i++) if (hist[b][i] == lvl[b]) all_diff = 0;
            if (all_diff) begin
                lvl[b] = hist[b][2];
                if (b == 2 && lvl[b]) prise = 1;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_outputs();
        logic exp_idle;
        exp_idle = (exp_control == 4'b0000) || (exp_control == 4'b1111);
        checks++;
        assert (control === exp_control) else begin
            errors++;
            $error("FAIL control: observed %b expected %b cycle %0d", control, exp_control, cycle_no);
        end
        checks++;
        assert (step_left === exp_sl) else begin
            errors++;
            $error("FAIL step_left: observed %b expected %b cycle %0d", step_left, exp_sl, cycle_no);
        end
        checks++;
        assert (step_right === exp_sr) else begin
            errors++;
            $error("FAIL step_right: observed %b expected %b cycle %0d", step_right, exp_sr, cycle_no);
        end
        checks++;
        assert (paused === exp_paused) else begin
            errors++;
            $error("FAIL paused: observed %b expected %b cycle %0d", paused, exp_paused, cycle_no);
        end
        checks++;
        assert ((step_left & step_right) === 1'b0) else begin
            errors++;
            $error("FAIL strobe_excl: observed %b%b expected not both high cycle %0d", step_left, step_right, cycle_no);
        end
        checks++;
        assert ((debug_dut.state == ST_IDLE) === exp_idle) else begin
            errors++;
            $error("FAIL state_idle: observed %b expected %b cycle %0d", debug_dut.state == ST_IDLE, exp_idle, cycle_no);
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic rst_v, input logic l, input logic r, input logic p);
        reset = rst_v; btn_left = l; btn_right = r; btn_pause = p;
        @(posedge clock);
        model_edge(rst_v, l, r, p);
        cycle_no++;
        #1;
        check_outputs();
    endtask

    task automatic hold_for(input int n, input logic l, input logic r, input logic p);
        for (int i = 0; i < n; i++) cycle(1'b1, l, r, p);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int strobes;
        // reset with every button held
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        assert (control === 4'b0000 && step_left === 1'b0 && step_right === 1'b0 && paused === 1'b0) else begin
            errors++;
            $error("FAIL reset_outputs: observed %b/%b/%b/%b expected 0000/0/0/0", control, step_left, step_right, paused);
        end
        hold_for(12, 1'b1, 1'b1, 1'b1);
        hold_for(12, 1'b0, 1'b0, 1'b0);
        hold_for(8, 1'b0, 1'b0, 1'b1);
        hold_for(12, 1'b0, 1'b0, 1'b0);

        // right press held 40 clocks
        for (int k = 1; k <= 40; k++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0);
            if (k == 6) begin
                checks++;
                assert (control === 4'b0000) else begin
                    errors++;
                    $error("FAIL right_pre_entry: observed %b expected 0000", control);
                end
            end
            if (k == 7) begin
                checks++;
                assert (control === 4'b0001 && step_right === 1'b1) else begin
                    errors++;
                    $error("FAIL right_entry: observed %b/%b expected 0001/1", control, step_right);
                end
            end
            if (k == 27) begin
                checks++;
                assert (control === 4'b0011) else begin
                    errors++;
                    $error("FAIL right_speed2: observed %b expected 0011", control);
                end
            end
        end
        hold_for(10, 1'b0, 1'b0, 1'b0);

        // bouncing left button
        strobes = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, (k / 2) % 2 == 0, 1'b0, 1'b0);
            strobes += int'(step_left) + int'(step_right) + int'(control != 4'b0000);
        end
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            strobes += int'(step_left) + int'(step_right) + int'(control != 4'b0000);
        end
        checks++;
        assert (strobes === 0) else begin
            errors++;
            $error("FAIL bounce_quiet: observed %0d activity cycles expected 0", strobes);
        end

        // both pressed, then left released
        hold_for(10, 1'b1, 1'b0, 1'b0);
        hold_for(12, 1'b1, 1'b1, 1'b0);
        hold_for(12, 1'b0, 1'b1, 1'b0);
        hold_for(10, 1'b0, 1'b0, 1'b0);

        // pause during LEFT2, unpause with left still held
        hold_for(30, 1'b1, 1'b0, 1'b0);
        hold_for(10, 1'b1, 1'b0, 1'b1);
        hold_for(10, 1'b1, 1'b0, 1'b0);
        hold_for(10, 1'b1, 1'b0, 1'b1);
        hold_for(10, 1'b1, 1'b0, 1'b0);
        hold_for(10, 1'b0, 1'b0, 1'b0);

        // reset during RIGHT2 with right held through it
        hold_for(35, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        hold_for(15, 1'b0, 1'b1, 1'b0);
        hold_for(10, 1'b0, 1'b0, 1'b0);

        // randomized segments
        for (int s = 0; s < 300; s++) begin
            logic l, r, p;
            int len;
            l = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 2) == 0);
            p = ($urandom_range(0, 7) == 0);
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 39) == 0) cycle(1'b0, l, r, p);
            hold_for(len, l, r, p);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
